bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the system bridge bus.
- Master 0 is the CPU data port; master 1 is a DMA/debug port. Both request bridge accesses to DM, TC0, TC1 and the interrupt register.
- The block grants the bus round-robin, latches the winning request, and drives the PR_addr/PR_WD/PR_byteen bus for the required number of cycles.
- It captures PR_RD for reads and returns a one-cycle ack/err to the requester. Unmapped addresses are rejected without bus activity.

Parameters:
- READ_LATENCY, 1, number of extra cycles the address is held before PR_RD is sampled for a read (0..15).
- CNT_W, 4, width of the latency counter; must hold READ_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held high with fields stable until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_byteen  in  4  master 0 write lane enables; ignored on reads.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_byteen  in  1/1/32/32/4  master 1, same meaning as master 0.
- m1_ack  out  1  one-cycle completion pulse to master 1.
- rdata  out  32  read data; valid only while an ack is high.
- err  out  1  decode error flag; valid only while an ack is high.
- busy  out  1  high in ACCESS and DONE.
- gnt_id  out  1  index of the latched master; valid while busy.
- PR_addr  out  32  bridge address.
- PR_WD  out  32  bridge write data.
- PR_byteen  out  4  bridge byte enables.
- PR_RD  in  32  bridge read data.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, prio=0, and every output is 0 (acks, err, rdata, busy, gnt_id, PR_addr, PR_WD, PR_byteen). Reset mid-access aborts the access and no ack is delivered; masters re-request.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from registered state only; no combinational path from m*_req to PR_*.
- IDLE:
  - If exactly one req is high, select that master. If both are high, select master `prio`.
  - Latch we/addr/wdata/byteen and the master index.
  - Mapped address ranges are 0x0000_0000-0x0000_2FFF, 0x0000_7F00-0x0000_7F0B, 0x0000_7F10-0x0000_7F1B and 0x0000_7F20-0x0000_7F23. If the address is mapped, go to ACCESS with cnt = we ? 0 : READ_LATENCY. Otherwise go to DONE with err_pending=1.
  - If no req is high, stay in IDLE.
- ACCESS:
  - PR_addr = latched address.
  - PR_WD = latched wdata when we=1, else 0.
  - PR_byteen = latched byteen only when we=1 and cnt equals its load value (the first ACCESS cycle, so a write commits exactly once); otherwise 4'b0.
  - If cnt==0: rdata_reg <= (we ? 0 : PR_RD), go to DONE. Else cnt <= cnt-1.
- DONE:
  - ack of the latched master = 1; rdata = rdata_reg; err = err_pending.
  - PR_* = 0.
  - prio <= ~gnt_id; go to IDLE. Unmapped accesses return rdata=0.
- Latency from req sampled high in IDLE (edge E) to ack high:
  - write: ACCESS for 1 cycle, ack in the 2nd cycle after E.
  - read: ACCESS for READ_LATENCY+1 cycles, ack READ_LATENCY+2 cycles after E.
  - decode error: ack in the 1st cycle after E.
- Back-to-back operation:
  - The FSM always passes through IDLE for ≥1 cycle between accesses.
  - A master still holding req in the IDLE cycle after its ack is treated as a new request.
  - Because prio flips after every completion, a contending master waits at most one access.
- Master-side rules:
  - A req withdrawn before its grant edge is ignored.
  - Changing fields or dropping req after the grant has no effect, because the fields are latched.
  - Acks are mutually exclusive. rdata and err are 0 when no ack is high.
- Write with byteen=0000: performs the ACCESS cycle with PR_byteen=0, then acks normally with err=0.

Test Plan:
- Reset, then m0 write addr 0x0000_0010, wdata 0xDEADBEEF, byteen 1111 -> PR_byteen=1111 for exactly 1 cycle with PR_addr=0x10 and PR_WD=0xDEADBEEF; m0_ack 2 cycles after the grant edge, err=0.
- READ_LATENCY=1, m1 read 0x0000_7F04 with PR_RD model returning 0x12345678 -> PR_addr=0x7F04 for 2 cycles, PR_byteen=0 throughout; m1_ack with rdata=0x12345678 3 cycles after the grant edge.
- m0 and m1 both request continuously from reset -> grant order 0,1,0,1; ack pulses alternate with one IDLE gap between accesses; no ack overlap.
- m0 read 0x0000_5000 (unmapped) -> no PR_* activity; m0_ack next cycle with err=1, rdata=0.
- Assert reset during the ACCESS cycle of an m1 read -> all outputs 0 immediately, no m1_ack; after release, prio=0 and m0 wins if both request.
- m0 write with byteen 0101 to 0x0000_7F20 -> PR_byteen=0101 for 1 cycle only; a second write immediately after the ack is granted after one IDLE cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter and sequencer for the bridge bus
// Outputs decode only from registered state, so no request input reaches PR_* combinationally.
module bus_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        gnt_id,
    output logic [31:0] PR_addr,
    output logic [31:0] PR_WD,
    output logic [3:0]  PR_byteen,
    input  logic [31:0] PR_RD
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY);

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        byteen_q, byteen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              sel;
    logic              sel_we;
    logic [31:0]       sel_addr;

    function automatic logic addr_mapped(input logic [31:0] a);
        return (a <= 32'h0000_2FFF)
            || (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B)
            || (a >= 32'h0000_7F10 && a <= 32'h0000_7F1B)
            || (a >= 32'h0000_7F20 && a <= 32'h0000_7F23);
    endfunction

    // With both requesting, prio decides; otherwise the lone requester wins.
    assign sel      = (m0_req && m1_req) ? prio_q : m1_req;
    assign sel_we   = sel ? m1_we   : m0_we;
    assign sel_addr = sel ? m1_addr : m0_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            byteen_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            byteen_q <= byteen_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        byteen_d = byteen_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d    = sel;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel ? m1_wdata  : m0_wdata;
                    byteen_d = sel ? m1_byteen : m0_byteen;
                    rdata_d  = '0;
                    if (addr_mapped(sel_addr)) begin
                        err_d   = 1'b0;
                        cnt_d   = sel_we ? '0 : RD_LOAD;
                        state_d = S_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = we_q ? '0 : PR_RD;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                prio_d  = ~gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign gnt_id    = gnt_q;
    assign m0_ack    = (state_q == S_DONE) && !gnt_q;
    assign m1_ack    = (state_q == S_DONE) &&  gnt_q;
    assign rdata     = (state_q == S_DONE) ? rdata_q : '0;
    assign err       = (state_q == S_DONE) && err_q;
    assign PR_addr   = (state_q == S_ACCESS) ? addr_q : '0;
    assign PR_WD     = (state_q == S_ACCESS && we_q) ? wdata_q : '0;
    // Writes load cnt with 0, so the enables appear on the single ACCESS cycle only.
    assign PR_byteen = (state_q == S_ACCESS && we_q && cnt_q == '0) ? byteen_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized self-checking bench for bus_arbiter against a transaction model
module tb_bus_arbiter;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m1_ack, err, busy, gnt_id;
    logic [31:0] rdata, PR_addr, PR_WD, PR_RD;
    logic [3:0]  PR_byteen;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] prd;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    bit   model_prio;

    bus_arbiter #(.READ_LATENCY(RL), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byteen(m0_byteen), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byteen(m1_byteen), .m1_ack(m1_ack),
        .rdata(rdata), .err(err), .busy(busy), .gnt_id(gnt_id),
        .PR_addr(PR_addr), .PR_WD(PR_WD), .PR_byteen(PR_byteen), .PR_RD(PR_RD)
    );

    always #5 clk = ~clk;

    function automatic bit model_mapped(input logic [31:0] a);
        logic [31:0] lo [4];
        logic [31:0] hi [4];
        lo = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
        hi = '{32'h0000_2FFF, 32'h0000_7F0B, 32'h0000_7F1B, 32'h0000_7F23};
        for (int i = 0; i < 4; i++)
            if (a >= lo[i] && a <= hi[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int txn_lat(input txn_t t);
        if (!model_mapped(t.addr)) return 1;
        return t.we ? 2 : RL + 2;
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] prd);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wd; t.be = be; t.prd = prd;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit force_write);
        txn_t t;
        logic [31:0] bl [5];
        bl = '{32'h0000_3000, 32'h0000_7F0C, 32'h0000_7F1C, 32'h0000_7F24, 32'h0000_7EFF};
        t.we = force_write ? 1'b1 : 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       t.addr = 32'($urandom_range(0, 32'h2FFF));
            1:       t.addr = 32'h7F00 + 32'($urandom_range(0, 11));
            2:       t.addr = 32'h7F10 + 32'($urandom_range(0, 11));
            3:       t.addr = 32'h7F20 + 32'($urandom_range(0, 3));
            4:       t.addr = bl[$urandom_range(0, 4)];
            default: t.addr = $urandom | 32'h0001_0000;
        endcase
        t.wdata = $urandom;
        t.be    = 4'($urandom_range(0, 15));
        t.prd   = $urandom;
        return t;
    endfunction

    task automatic drive_masters();
        m0_req = (q0.size() != 0);
        m1_req = (q1.size() != 0);
        if (m0_req) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; m0_byteen = q0[0].be;
        end else begin
            m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
        end
        if (m1_req) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; m1_byteen = q1[0].be;
        end else begin
            m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
        end
    endtask

    function automatic bit pick(output int w);
        w = 0;
        if (q0.size() != 0 && q1.size() != 0) w = int'(model_prio);
        else if (q1.size() != 0)             w = 1;
        else if (q0.size() == 0)             return 1'b0;
        return 1'b1;
    endfunction

    // Runs both queues to completion; the model predicts every cycle of bus and ack activity.
    task automatic run_stream(input string tag);
        int k = 0, s0 = 0, lat = 0, w = 0, guard = 0;
        bit active;
        txn_t t;
        logic e_a0, e_a1, e_busy, e_err;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0] e_be;
        drive_masters();
        active = pick(w);
        if (active) begin
            t = (w == 1) ? q1[0] : q0[0];
            lat = txn_lat(t);
            PR_RD = t.prd;
        end
        while (guard < 2000) begin
            @(posedge clk); #1;
            k++; guard++;
            e_a0 = 0; e_a1 = 0; e_busy = 0; e_err = 0;
            e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
            if (active && k > s0 && k < s0 + lat) begin
                e_busy = 1;
                e_addr = t.addr;
                e_wd   = t.we ? t.wdata : 32'h0;
                e_be   = (t.we && k == s0 + 1) ? t.be : 4'h0;
            end else if (active && k == s0 + lat) begin
                e_busy = 1;
                e_a0   = (w == 0);
                e_a1   = (w == 1);
                e_err  = !model_mapped(t.addr);
                e_rd   = (model_mapped(t.addr) && !t.we) ? t.prd : 32'h0;
            end
            checks++;
            if ({m0_ack, m1_ack} !== {e_a0, e_a1}) begin
                errors++;
                $display("FAIL %s acks cyc %0d got %b%b exp %b%b", tag, k, m0_ack, m1_ack, e_a0, e_a1);
            end
            checks++;
            if ({rdata, err} !== {e_rd, e_err}) begin
                errors++;
                $display("FAIL %s rdata/err cyc %0d got %h/%b exp %h/%b", tag, k, rdata, err, e_rd, e_err);
            end
            checks++;
            if ({PR_addr, PR_WD, PR_byteen} !== {e_addr, e_wd, e_be}) begin
                errors++;
                $display("FAIL %s pr_bus cyc %0d got %h %h %b exp %h %h %b",
                         tag, k, PR_addr, PR_WD, PR_byteen, e_addr, e_wd, e_be);
            end
            checks++;
            if (busy !== e_busy || (e_busy && gnt_id !== 1'(w))) begin
                errors++;
                $display("FAIL %s busy/gnt cyc %0d got %b/%b exp %b/%0d", tag, k, busy, gnt_id, e_busy, w);
            end
            if (active && k == s0 + lat) begin
                model_prio = (w == 0);
                if (w == 1) q1.delete(0); else q0.delete(0);
                drive_masters();
                s0 = k + 1;
                active = pick(w);
                if (active) begin
                    t = (w == 1) ? q1[0] : q0[0];
                    lat = txn_lat(t);
                    PR_RD = t.prd;
                end
            end else if (!active) begin
                break;
            end
        end
        if (guard >= 2000) begin
            errors++;
            $display("FAIL %s timeout got %0d cycles exp under 2000", tag, guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q0.delete(); q1.delete();
        drive_masters();
        PR_RD = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m0_ack, m1_ack, rdata, err, busy, gnt_id, PR_addr, PR_WD, PR_byteen} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %h %b %b %b %h %h %b exp all zero",
                     m0_ack, m1_ack, rdata, err, busy, gnt_id, PR_addr, PR_WD, PR_byteen);
        end
        reset = 1'b0;
        model_prio = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || PR_byteen !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle got busy %b be %b exp 0 0", busy, PR_byteen);
        end
    endtask

    task automatic test_write();
        q0.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0));
        run_stream("write_m0");
    endtask

    task automatic test_read();
        q1.push_back(mk(1'b0, 32'h0000_7F04, 32'h0, 4'b1010, 32'h1234_5678));
        run_stream("read_m1");
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_txn(1'b0));
            q1.push_back(rand_txn(1'b0));
        end
        run_stream("contention");
    endtask

    task automatic test_decode_error();
        q0.push_back(mk(1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'hA5A5_A5A5));
        run_stream("decode_err");
    endtask

    task automatic test_reset_abort();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_7F04; m1_wdata = '0; m1_byteen = '0;
        PR_RD = 32'hCAFE_F00D;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || PR_addr !== 32'h7F04 || gnt_id !== 1'b1) begin
            errors++;
            $display("FAIL abort_access got busy %b addr %h gnt %b exp 1 00007f04 1", busy, PR_addr, gnt_id);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({m0_ack, m1_ack, rdata, err, busy, gnt_id, PR_addr, PR_WD, PR_byteen} !== '0) begin
            errors++;
            $display("FAIL abort_async got %b %b %h %b %b %b %h %h %b exp all zero",
                     m0_ack, m1_ack, rdata, err, busy, gnt_id, PR_addr, PR_WD, PR_byteen);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (m1_ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_noack got ack %b busy %b exp 0 0", m1_ack, busy);
            end
        end
        m1_req = 1'b0;
        reset = 1'b0;
        model_prio = 1'b0;
        @(posedge clk); #1;
        q0.push_back(rand_txn(1'b1));
        q1.push_back(rand_txn(1'b1));
        run_stream("abort_prio");
    endtask

    task automatic test_back_to_back();
        q0.push_back(mk(1'b1, 32'h0000_7F20, $urandom, 4'b0101, 32'h0));
        q0.push_back(rand_txn(1'b1));
        run_stream("back_to_back");
    endtask

    task automatic test_byteen_zero();
        q1.push_back(mk(1'b1, 32'h0000_0100, 32'h1357_9BDF, 4'b0000, 32'h0));
        run_stream("byteen_zero");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n0 = $urandom_range(0, 5);
            int n1 = $urandom_range(0, 5);
            for (int i = 0; i < n0; i++) q0.push_back(rand_txn(1'b0));
            for (int i = 0; i < n1; i++) q1.push_back(rand_txn(1'b0));
            run_stream("random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_decode_error();
        test_reset_abort();
        test_back_to_back();
        test_byteen_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
